// File: rtl/bus_pkg.sv
// Shared definitions for the simple-system bus host arbiter: request bundle
// layout and the host-ID width helper.
package bus_pkg;

   localparam int BusAddrW = 32;
   localparam int BusDataW = 32;
   localparam int BusBeW   = BusDataW / 8;

   typedef struct packed {
      logic [BusAddrW-1:0] addr;
      logic                we;
      logic [BusBeW-1:0]   be;
      logic [BusDataW-1:0] wdata;
   } bus_req_t;

   // A single host still needs a one-bit ID so that the FIFO has a real width.
   function automatic int host_id_width(input int nr_hosts);
      return (nr_hosts <= 2) ? 1 : $clog2(nr_hosts);
   endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order ID tracking FIFO: push on grant, pop on response, head is the
// owner of the oldest outstanding transaction.
module bus_arb_id_fifo #(
   parameter int IdW   = 1,
   parameter int Depth = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  logic [IdW-1:0] id_i,
   input  logic           pop_i,
   output logic           full_o,
   output logic           empty_o,
   output logic [IdW-1:0] head_o
);

   localparam int PtrW = (Depth <= 1) ? 1 : $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);

   logic [IdW-1:0]  mem_q [Depth];
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rptr_q];

   // A full FIFO refuses pushes even when it pops in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= id_i;
   end

endmodule

// File: rtl/bus_host_arb.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus port between NrHosts
// hosts; responses are routed back in order through an ID FIFO.
module bus_host_arb
   import bus_pkg::*;
#(
   parameter int NrHosts        = 2,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NrHosts-1:0]                  host_req_i,
   output logic [NrHosts-1:0]                  host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]     host_addr_i,
   input  logic [NrHosts-1:0]                  host_we_i,
   input  logic [NrHosts*(DataWidth/8)-1:0]    host_be_i,
   input  logic [NrHosts*DataWidth-1:0]        host_wdata_i,
   output logic [NrHosts-1:0]                  host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]        host_rdata_o,
   output logic [NrHosts-1:0]                  host_err_o,
   output logic                                dev_req_o,
   input  logic                                dev_gnt_i,
   output logic [AddressWidth-1:0]             dev_addr_o,
   output logic                                dev_we_o,
   output logic [DataWidth/8-1:0]              dev_be_o,
   output logic [DataWidth-1:0]                dev_wdata_o,
   input  logic                                dev_rvalid_i,
   input  logic [DataWidth-1:0]                dev_rdata_i,
   input  logic                                dev_err_i,
   output logic                                resp_unexpected_o
);

   localparam int IdW = host_id_width(NrHosts);
   localparam int BeW = DataWidth / 8;

   logic [IdW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, sel, head;
   logic           lock_q, lock_d, sel_valid;
   logic           fifo_full, fifo_empty, grant, pop;

   // Locked selection wins; otherwise search ptr..NrHosts-1, then wrap from 0.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      if (lock_q && host_req_i[lock_idx_q]) begin
         sel       = lock_idx_q;
         sel_valid = 1'b1;
      end else begin
         for (int h = 0; h < NrHosts; h++) begin
            if (!sel_valid && host_req_i[h] && (IdW'(h) >= ptr_q)) begin
               sel       = IdW'(h);
               sel_valid = 1'b1;
            end
         end
         for (int h = 0; h < NrHosts; h++) begin
            if (!sel_valid && host_req_i[h]) begin
               sel       = IdW'(h);
               sel_valid = 1'b1;
            end
         end
      end
   end

   // Outputs are gated by rst_ni so they read 0 as soon as reset asserts.
   assign dev_req_o         = rst_ni && sel_valid && !fifo_full;
   assign grant             = dev_req_o && dev_gnt_i;
   assign pop               = rst_ni && dev_rvalid_i && !fifo_empty;
   assign resp_unexpected_o = rst_ni && dev_rvalid_i && fifo_empty;

   always_comb begin
      dev_addr_o  = '0;
      dev_we_o    = 1'b0;
      dev_be_o    = '0;
      dev_wdata_o = '0;
      for (int h = 0; h < NrHosts; h++) begin
         if (dev_req_o && (sel == IdW'(h))) begin
            dev_addr_o  = host_addr_i[h*AddressWidth +: AddressWidth];
            dev_we_o    = host_we_i[h];
            dev_be_o    = host_be_i[h*BeW +: BeW];
            dev_wdata_o = host_wdata_i[h*DataWidth +: DataWidth];
         end
      end
   end

   always_comb begin
      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      host_rdata_o  = '0;
      for (int h = 0; h < NrHosts; h++) begin
         host_gnt_o[h]    = grant && (sel == IdW'(h));
         host_rvalid_o[h] = pop && (head == IdW'(h));
         host_err_o[h]    = pop && (head == IdW'(h)) && dev_err_i;
         host_rdata_o[h*DataWidth +: DataWidth] =
            (pop && (head == IdW'(h))) ? dev_rdata_i : '0;
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (grant) begin
         ptr_d  = (sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1);
         lock_d = 1'b0;
      end else if (dev_req_o) begin
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end else if (lock_q && !host_req_i[lock_idx_q]) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   bus_arb_id_fifo #(
      .IdW   (IdW),
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (grant),
      .id_i    (sel),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

endmodule

// File: tb/tb_bus_host_arb.sv
// Testbench for bus_host_arb: directed vector table, reset-in-flight sequence
// and a randomized phase against a queue-based reference model.
module tb_bus_host_arb;
   import bus_pkg::*;

   localparam int N   = 2;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int MO  = 2;
   localparam int IdW = 1;

   logic               clk, rst_n;
   logic [N-1:0]       host_req, host_gnt, host_we, host_rvalid, host_err;
   logic [N*AW-1:0]    host_addr;
   logic [N*DW/8-1:0]  host_be;
   logic [N*DW-1:0]    host_wdata, host_rdata;
   logic               dev_req, dev_gnt, dev_we, dev_rvalid, dev_err, resp_unexpected;
   logic [AW-1:0]      dev_addr;
   logic [DW/8-1:0]    dev_be;
   logic [DW-1:0]      dev_wdata, dev_rdata;

   int total = 0;
   int bad   = 0;

   bus_req_t hreq [N];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   bus_host_arb #(
      .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
      .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
      .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
      .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
      .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
      .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
      .resp_unexpected_o(resp_unexpected)
   );

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [N-1:0] req, input logic g, input logic rv,
                        input logic e, input logic [DW-1:0] rd);
      host_req = req;
      for (int h = 0; h < N; h++) begin
         host_addr[h*AW +: AW]         = hreq[h].addr;
         host_we[h]                    = hreq[h].we;
         host_be[h*(DW/8) +: (DW/8)]   = hreq[h].be;
         host_wdata[h*DW +: DW]        = hreq[h].wdata;
      end
      dev_gnt    = g;
      dev_rvalid = rv;
      dev_err    = e;
      dev_rdata  = rd;
   endtask

   typedef struct {
      logic [N-1:0]  req;
      logic          dgnt;
      logic          rv;
      logic          derr;
      logic [DW-1:0] rdata;
      logic          edreq;
      logic [N-1:0]  egnt;
      logic [AW-1:0] eaddr;
      logic [N-1:0]  erv;
      logic [N-1:0]  eerr;
      logic          eunx;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(input logic [1:0] req, input logic dgnt, input logic rv,
                               input logic derr, input logic [31:0] rdata,
                               input logic edreq, input logic [1:0] egnt,
                               input logic [31:0] eaddr, input logic [1:0] erv,
                               input logic [1:0] eerr, input logic eunx);
      vec_t v;
      v.req = req; v.dgnt = dgnt; v.rv = rv; v.derr = derr; v.rdata = rdata;
      v.edreq = edreq; v.egnt = egnt; v.eaddr = eaddr; v.erv = erv;
      v.eerr = eerr; v.eunx = eunx;
      return v;
   endfunction

   task automatic apply_vec(input vec_t v, input string tag);
      logic [N*DW-1:0] exp_rdata;
      @(negedge clk);
      drive(v.req, v.dgnt, v.rv, v.derr, v.rdata);
      #1;
      exp_rdata = '0;
      for (int h = 0; h < N; h++)
         if (v.erv[h]) exp_rdata[h*DW +: DW] = v.rdata;
      chk({tag, ".dev_req"},    128'(dev_req),         128'(v.edreq));
      chk({tag, ".host_gnt"},   128'(host_gnt),        128'(v.egnt));
      chk({tag, ".dev_addr"},   128'(dev_addr),        128'(v.eaddr));
      chk({tag, ".host_rvalid"},128'(host_rvalid),     128'(v.erv));
      chk({tag, ".host_err"},   128'(host_err),        128'(v.eerr));
      chk({tag, ".unexpected"}, 128'(resp_unexpected), 128'(v.eunx));
      chk({tag, ".host_rdata"}, 128'(host_rdata),      128'(exp_rdata));
   endtask

   // ---------------- scoreboard / reference model ----------------
   logic [IdW-1:0] exp_q [$];
   logic           pend [N];
   int             m_ptr, m_held;

   task automatic random_phase(input int cycles);
      int            sel;
      logic          full, e_dreq, g, rv, de;
      logic [DW-1:0] rd;
      logic [N-1:0]  e_gnt, e_rv, e_err;
      logic          e_unx;
      logic [N*DW-1:0] e_rdata;
      bus_req_t      e_dev;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int h = 0; h < N; h++) begin
            if (!pend[h] && $urandom_range(0, 2) == 0) begin
               pend[h]        = 1'b1;
               hreq[h].addr   = $urandom;
               hreq[h].we     = 1'($urandom_range(0, 1));
               hreq[h].be     = 4'($urandom_range(0, 15));
               hreq[h].wdata  = $urandom;
            end
         end
         g  = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 9) < 4);
         de = 1'($urandom_range(0, 1));
         rd = $urandom;
         drive({pend[1], pend[0]}, g, rv, de, rd);

         full = (exp_q.size() >= MO);
         sel  = -1;
         if (m_held >= 0) sel = m_held;
         else
            for (int k = 0; k < N; k++)
               if (sel < 0 && pend[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
         e_dreq  = (sel >= 0) && !full;
         e_gnt   = '0;
         e_dev   = '0;
         if (e_dreq) e_dev = hreq[sel];
         if (e_dreq && g) e_gnt[sel] = 1'b1;
         e_rv    = '0;
         e_err   = '0;
         e_rdata = '0;
         e_unx   = rv && (exp_q.size() == 0);
         if (rv && exp_q.size() > 0) begin
            e_rv[exp_q[0]]  = 1'b1;
            e_err[exp_q[0]] = de;
            e_rdata[int'(exp_q[0])*DW +: DW] = rd;
         end

         #1;
         chk("rnd.dev_req",     128'(dev_req),         128'(e_dreq));
         chk("rnd.host_gnt",    128'(host_gnt),        128'(e_gnt));
         chk("rnd.dev_fields",  128'({dev_addr, dev_we, dev_be, dev_wdata}), 128'(e_dev));
         chk("rnd.host_rvalid", 128'(host_rvalid),     128'(e_rv));
         chk("rnd.host_err",    128'(host_err),        128'(e_err));
         chk("rnd.unexpected",  128'(resp_unexpected), 128'(e_unx));
         chk("rnd.host_rdata",  128'(host_rdata),      128'(e_rdata));

         if (rv && exp_q.size() > 0) void'(exp_q.pop_front());
         if (e_dreq && g) begin
            exp_q.push_back(IdW'(sel));
            m_ptr     = (sel + 1) % N;
            m_held    = -1;
            pend[sel] = 1'b0;
         end else if (e_dreq) begin
            m_held = sel;
         end
      end
   endtask

   // ---------------- test sequence ----------------
   localparam logic [31:0] A0 = 32'h1000_0040;
   localparam logic [31:0] A1 = 32'h2000_0080;

   initial begin
      hreq[0] = '{addr: A0, we: 1'b1, be: 4'hF, wdata: 32'hAAAA_0000};
      hreq[1] = '{addr: A1, we: 1'b0, be: 4'h3, wdata: 32'h0000_5555};
      rst_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      //              req   g rv er rdata          dreq gnt   addr  rv    err   unx
      vecs.push_back(mk(2'b00,0,0,0,32'h0,         0,2'b00,32'h0,2'b00,2'b00,0));
      vecs.push_back(mk(2'b11,1,0,0,32'h0,         1,2'b01,A0,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b10,1,1,0,32'hDEADBEEF,  1,2'b10,A1,   2'b01,2'b00,0));
      vecs.push_back(mk(2'b00,0,1,1,32'h12345678,  0,2'b00,32'h0,2'b10,2'b10,0));
      vecs.push_back(mk(2'b00,0,1,0,32'h0BADF00D,  0,2'b00,32'h0,2'b00,2'b00,1));
      vecs.push_back(mk(2'b00,0,0,0,32'h0,         0,2'b00,32'h0,2'b00,2'b00,0));
      vecs.push_back(mk(2'b01,1,0,0,32'h0,         1,2'b01,A0,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b01,1,0,0,32'h0,         1,2'b01,A0,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b01,1,0,0,32'h0,         0,2'b00,32'h0,2'b00,2'b00,0));
      vecs.push_back(mk(2'b01,1,1,0,32'h11111111,  0,2'b00,32'h0,2'b01,2'b00,0));
      vecs.push_back(mk(2'b01,1,0,0,32'h0,         1,2'b01,A0,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b00,0,1,0,32'h22222222,  0,2'b00,32'h0,2'b01,2'b00,0));
      vecs.push_back(mk(2'b00,0,1,0,32'h33333333,  0,2'b00,32'h0,2'b01,2'b00,0));
      vecs.push_back(mk(2'b10,1,0,0,32'h0,         1,2'b10,A1,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b00,0,1,0,32'h44444444,  0,2'b00,32'h0,2'b10,2'b00,0));
      vecs.push_back(mk(2'b10,0,0,0,32'h0,         1,2'b00,A1,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b11,0,0,0,32'h0,         1,2'b00,A1,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b11,0,0,0,32'h0,         1,2'b00,A1,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b11,1,0,0,32'h0,         1,2'b10,A1,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b01,1,0,0,32'h0,         1,2'b01,A0,   2'b00,2'b00,0));
      vecs.push_back(mk(2'b00,0,1,0,32'h55555555,  0,2'b00,32'h0,2'b10,2'b00,0));
      vecs.push_back(mk(2'b00,0,1,1,32'h66666666,  0,2'b00,32'h0,2'b01,2'b01,0));
      vecs.push_back(mk(2'b00,0,0,0,32'h0,         0,2'b00,32'h0,2'b00,2'b00,0));
      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset with two transactions in flight and every input active.
      apply_vec(mk(2'b01,1,0,0,32'h0, 1,2'b01,A0,2'b00,2'b00,0), "rst.g0");
      apply_vec(mk(2'b01,1,0,0,32'h0, 1,2'b01,A0,2'b00,2'b00,0), "rst.g1");
      apply_vec(mk(2'b11,1,0,0,32'h0, 0,2'b00,32'h0,2'b00,2'b00,0), "rst.full");
      drive(2'b11, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst.dev_req",     128'(dev_req),         128'(0));
      chk("rst.host_gnt",    128'(host_gnt),        128'(0));
      chk("rst.host_rvalid", 128'(host_rvalid),     128'(0));
      chk("rst.host_err",    128'(host_err),        128'(0));
      chk("rst.unexpected",  128'(resp_unexpected), 128'(0));
      chk("rst.dev_fields",  128'({dev_addr, dev_we, dev_be, dev_wdata}), 128'(0));
      chk("rst.host_rdata",  128'(host_rdata),      128'(0));
      @(negedge clk);
      drive(2'b00, 1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b1;
      apply_vec(mk(2'b00,0,1,0,32'h77777777, 0,2'b00,32'h0,2'b00,2'b00,1), "post.stale");
      apply_vec(mk(2'b10,1,0,0,32'h0,        1,2'b10,A1,   2'b00,2'b00,0), "post.g1");
      apply_vec(mk(2'b00,0,1,0,32'h88888888, 0,2'b00,32'h0,2'b10,2'b00,0), "post.rsp");
      apply_vec(mk(2'b00,0,0,0,32'h0,        0,2'b00,32'h0,2'b00,2'b00,0), "post.idle");

      m_ptr  = 0;
      m_held = -1;
      exp_q.delete();
      for (int h = 0; h < N; h++) pend[h] = 1'b0;
      random_phase(600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
